// File: rtl/output_writeback_ctrl.sv
// Output-buffer to DRAM write-back controller: fetches entries, serialises them into DRAM beats.
// Optional macro WB_RELU_EN clamps negative lanes to zero at capture.
module output_writeback_ctrl #(
  parameter int unsigned DRAM_ADDR_WIDTH    = 18,
  parameter int unsigned OUTPUT_ADDR_WIDTH  = 16,
  parameter int unsigned DATA_IN_DRAM_WIDTH = 32,
  parameter int unsigned N_COLS_ARRAY       = 16,
  parameter int unsigned O_WIDTH            = 8
) (
  input  logic                              clk_i,
  input  logic                              general_rst_i,
  input  logic                              start_i,
  input  logic [DRAM_ADDR_WIDTH-1:0]        output_start_addr_dram_i,
  input  logic [OUTPUT_ADDR_WIDTH:0]        output_count_i,
  output logic [OUTPUT_ADDR_WIDTH-1:0]      obuf_rd_address_o,
  input  logic [O_WIDTH*N_COLS_ARRAY-1:0]   obuf_rd_data_i,
  output logic                              dram_wr_en_o,
  input  logic                              dram_wr_ready_i,
  output logic [DRAM_ADDR_WIDTH-1:0]        dram_wr_address_o,
  output logic [DATA_IN_DRAM_WIDTH-1:0]     dram_wr_data_o,
  output logic                              done_o,
  output logic [2:0]                        wb_state_o
);

  localparam int unsigned ENTRY_W = O_WIDTH * N_COLS_ARRAY;
  localparam int unsigned BEATS   = (ENTRY_W + DATA_IN_DRAM_WIDTH - 1) / DATA_IN_DRAM_WIDTH;
  localparam int unsigned PAD_W   = BEATS * DATA_IN_DRAM_WIDTH;
  localparam int unsigned BEAT_W  = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int unsigned CNT_W   = OUTPUT_ADDR_WIDTH + 1;

  typedef enum logic [2:0] {
    IDLE  = 3'b000,
    FETCH = 3'b001,
    LATCH = 3'b010,
    WRITE = 3'b011,
    DONE  = 3'b100
  } wb_state_t;

  wb_state_t          state_q;
  logic [CNT_W-1:0]   count_q;
  logic [CNT_W-1:0]   entry_idx_q;
  logic [CNT_W-1:0]   entry_idx_nxt;
  logic [BEAT_W-1:0]  beat_q;
  logic [BEAT_W-1:0]  beat_nxt;
  logic               last_beat;
  logic               last_entry;
  logic [PAD_W-1:0]   entry_q;
  logic [PAD_W-1:0]   captured;

  // Lane-wise clamp applied to the entry as it is captured.
  function automatic logic [ENTRY_W-1:0] lane_filter(input logic [ENTRY_W-1:0] v);
    logic [ENTRY_W-1:0] r;
    r = v;
`ifdef WB_RELU_EN
    for (int i = 0; i < int'(N_COLS_ARRAY); i++) begin
      if (v[i*O_WIDTH + O_WIDTH - 1]) r[i*O_WIDTH +: O_WIDTH] = '0;
    end
`endif
    return r;
  endfunction

  assign captured      = PAD_W'(lane_filter(obuf_rd_data_i));
  assign beat_nxt      = beat_q + BEAT_W'(1);
  assign entry_idx_nxt = entry_idx_q + CNT_W'(1);
  assign last_beat     = (beat_q == BEAT_W'(BEATS - 1));
  assign last_entry    = (entry_idx_nxt == count_q);
  assign wb_state_o    = state_q;

  // Single-process FSM; every output is a register updated alongside the state.
  always_ff @(posedge clk_i or posedge general_rst_i) begin
    if (general_rst_i) begin
      state_q           <= IDLE;
      count_q           <= '0;
      entry_idx_q       <= '0;
      beat_q            <= '0;
      entry_q           <= '0;
      obuf_rd_address_o <= '0;
      dram_wr_en_o      <= 1'b0;
      dram_wr_address_o <= '0;
      dram_wr_data_o    <= '0;
      done_o            <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start_i) begin
            count_q           <= output_count_i;
            dram_wr_address_o <= output_start_addr_dram_i;
            entry_idx_q       <= '0;
            beat_q            <= '0;
            if (output_count_i == '0) begin
              state_q <= DONE;
              done_o  <= 1'b1;
            end else begin
              state_q           <= FETCH;
              obuf_rd_address_o <= '0;
            end
          end
        end
        FETCH: begin
          state_q <= LATCH;
        end
        LATCH: begin
          entry_q        <= captured;
          dram_wr_data_o <= captured[DATA_IN_DRAM_WIDTH-1:0];
          beat_q         <= '0;
          dram_wr_en_o   <= 1'b1;
          state_q        <= WRITE;
        end
        WRITE: begin
          // Address and data only move on an accepted beat, so a stall holds them.
          if (dram_wr_ready_i) begin
            dram_wr_address_o <= dram_wr_address_o + DRAM_ADDR_WIDTH'(1);
            if (last_beat) begin
              dram_wr_en_o <= 1'b0;
              if (last_entry) begin
                state_q <= DONE;
                done_o  <= 1'b1;
              end else begin
                entry_idx_q       <= entry_idx_nxt;
                obuf_rd_address_o <= entry_idx_nxt[OUTPUT_ADDR_WIDTH-1:0];
                state_q           <= FETCH;
              end
            end else begin
              beat_q         <= beat_nxt;
              dram_wr_data_o <= entry_q[int'(beat_nxt)*DATA_IN_DRAM_WIDTH +: DATA_IN_DRAM_WIDTH];
            end
          end
        end
        DONE: begin
          if (!start_i) begin
            state_q <= IDLE;
            done_o  <= 1'b0;
          end
        end
        default: begin
          state_q      <= IDLE;
          dram_wr_en_o <= 1'b0;
          done_o       <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_output_writeback_ctrl.sv
// Directed bench for output_writeback_ctrl: latency, stall, zero count, address wrap, reset abort, lane clamp.
module tb_output_writeback_ctrl;

  logic          clk_i = 1'b0;
  logic          general_rst_i = 1'b1;
  logic          start_i = 1'b0;
  logic [17:0]   output_start_addr_dram_i = '0;
  logic [16:0]   output_count_i = '0;
  logic [15:0]   obuf_rd_address_o;
  logic [127:0]  obuf_rd_data_i = '0;
  logic          dram_wr_en_o;
  logic          dram_wr_ready_i = 1'b1;
  logic [17:0]   dram_wr_address_o;
  logic [31:0]   dram_wr_data_o;
  logic          done_o;
  logic [2:0]    wb_state_o;

  output_writeback_ctrl dut (
    .clk_i                    (clk_i),
    .general_rst_i            (general_rst_i),
    .start_i                  (start_i),
    .output_start_addr_dram_i (output_start_addr_dram_i),
    .output_count_i           (output_count_i),
    .obuf_rd_address_o        (obuf_rd_address_o),
    .obuf_rd_data_i           (obuf_rd_data_i),
    .dram_wr_en_o             (dram_wr_en_o),
    .dram_wr_ready_i          (dram_wr_ready_i),
    .dram_wr_address_o        (dram_wr_address_o),
    .dram_wr_data_o           (dram_wr_data_o),
    .done_o                   (done_o),
    .wb_state_o               (wb_state_o)
  );

  always #5 clk_i = ~clk_i;

  int n_checks = 0;
  int n_errors = 0;

  logic [127:0] mem [0:7];
  logic [17:0]  log_addr [$];
  logic [31:0]  log_data [$];
  logic         en_seen = 1'b0;

  // Buffer model: data follows its address by one cycle.
  always @(posedge clk_i) obuf_rd_data_i <= mem[obuf_rd_address_o[2:0]];

  // Beat monitor: records every accepted beat.
  always @(posedge clk_i) begin
    if (dram_wr_en_o) en_seen <= 1'b1;
    if (dram_wr_en_o && dram_wr_ready_i) begin
      log_addr.push_back(dram_wr_address_o);
      log_data.push_back(dram_wr_data_o);
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] exp_word(input int e, input int b);
    logic [31:0] w;
    for (int k = 0; k < 4; k++) w[k*8 +: 8] = 8'(e*16 + b*4 + k);
    return w;
  endfunction

  task automatic run_start(input logic [17:0] addr, input logic [16:0] cnt);
    repeat (2) @(posedge clk_i);
    log_addr.delete();
    log_data.delete();
    en_seen = 1'b0;
    @(negedge clk_i);
    start_i = 1'b1;
    output_start_addr_dram_i = addr;
    output_count_i = cnt;
    @(posedge clk_i);
    #1;
    start_i = 1'b0;
  endtask

  task automatic wait_done(input int budget, output int cyc);
    cyc = 0;
    while (cyc < budget && !done_o) begin
      @(posedge clk_i);
      #1;
      cyc++;
    end
    if (!done_o) check("done_timeout", 64'(done_o), 64'd1);
  endtask

  task automatic wait_beats(input int n, input int budget);
    int c;
    c = 0;
    while (c < budget && log_addr.size() < n) begin
      @(posedge clk_i);
      #1;
      c++;
    end
    if (log_addr.size() < n) check("beat_timeout", 64'(log_addr.size()), 64'(n));
  endtask

  initial begin
    int cyc;
    for (int e = 0; e < 8; e++)
      for (int i = 0; i < 16; i++) mem[e][i*8 +: 8] = 8'(e*16 + i);

    // Reset state
    repeat (3) @(posedge clk_i);
    #1;
    check("rst_state", 64'(wb_state_o), 64'd0);
    check("rst_en", 64'(dram_wr_en_o), 64'd0);
    check("rst_done", 64'(done_o), 64'd0);
    check("rst_addr", 64'(dram_wr_address_o), 64'd0);
    check("rst_data", 64'(dram_wr_data_o), 64'd0);
    check("rst_obuf_addr", 64'(obuf_rd_address_o), 64'd0);
    @(negedge clk_i);
    general_rst_i = 1'b0;

    // Two entries, no backpressure
    run_start(18'h100, 17'd2);
    wait_done(40, cyc);
    check("t1_latency", 64'(cyc), 64'd12);
    check("t1_state_done", 64'(wb_state_o), 64'd4);
    check("t1_nbeats", 64'(log_addr.size()), 64'd8);
    check("t1_first_beat", 64'(log_data[0]), 64'h03020100);
    check("t1_last_beat", 64'(log_data[7]), 64'h1F1E1D1C);
    for (int b = 0; b < 8 && b < log_addr.size(); b++) begin
      check($sformatf("t1_addr%0d", b), 64'(log_addr[b]), 64'(18'h100 + b));
      check($sformatf("t1_data%0d", b), 64'(log_data[b]), 64'(exp_word(b / 4, b % 4)));
    end
    @(posedge clk_i);
    #1;
    check("t1_back_idle", 64'(wb_state_o), 64'd0);
    check("t1_done_clear", 64'(done_o), 64'd0);

    // Backpressure on the third beat
    run_start(18'h200, 17'd1);
    wait_beats(2, 40);
    dram_wr_ready_i = 1'b0;
    for (int s = 0; s < 3; s++) begin
      @(posedge clk_i);
      #1;
      check($sformatf("t2_hold_addr%0d", s), 64'(dram_wr_address_o), 64'h202);
      check($sformatf("t2_hold_data%0d", s), 64'(dram_wr_data_o), 64'h0B0A0908);
      check($sformatf("t2_hold_en%0d", s), 64'(dram_wr_en_o), 64'd1);
    end
    dram_wr_ready_i = 1'b1;
    wait_done(40, cyc);
    check("t2_nbeats", 64'(log_addr.size()), 64'd4);
    if (log_addr.size() == 4) begin
      check("t2_beat2_addr", 64'(log_addr[2]), 64'h202);
      check("t2_beat2_data", 64'(log_data[2]), 64'h0B0A0908);
      check("t2_beat3_addr", 64'(log_addr[3]), 64'h203);
      check("t2_beat3_data", 64'(log_data[3]), 64'h0F0E0D0C);
    end

    // Zero count, start held high must not retrigger
    repeat (2) @(posedge clk_i);
    en_seen = 1'b0;
    @(negedge clk_i);
    start_i = 1'b1;
    output_start_addr_dram_i = 18'h300;
    output_count_i = 17'd0;
    @(posedge clk_i);
    #1;
    check("t3_state", 64'(wb_state_o), 64'd4);
    check("t3_done", 64'(done_o), 64'd1);
    repeat (3) @(posedge clk_i);
    #1;
    check("t3_held", 64'(wb_state_o), 64'd4);
    start_i = 1'b0;
    @(posedge clk_i);
    #1;
    check("t3_idle", 64'(wb_state_o), 64'd0);
    check("t3_no_en", 64'(en_seen), 64'd0);

    // Address wrap
    run_start(18'h3FFFE, 17'd1);
    wait_done(40, cyc);
    check("t4_nbeats", 64'(log_addr.size()), 64'd4);
    if (log_addr.size() == 4) begin
      check("t4_a0", 64'(log_addr[0]), 64'h3FFFE);
      check("t4_a1", 64'(log_addr[1]), 64'h3FFFF);
      check("t4_a2", 64'(log_addr[2]), 64'h00000);
      check("t4_a3", 64'(log_addr[3]), 64'h00001);
    end

    // Reset during the third beat of entry 5
    run_start(18'h000, 17'd8);
    wait_beats(22, 300);
    check("t5_pending_data", 64'(dram_wr_data_o), 64'(exp_word(5, 2)));
    general_rst_i = 1'b1;
    #1;
    check("t5_rst_en", 64'(dram_wr_en_o), 64'd0);
    check("t5_rst_state", 64'(wb_state_o), 64'd0);
    check("t5_rst_addr", 64'(dram_wr_address_o), 64'd0);
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    general_rst_i = 1'b0;
    repeat (10) @(posedge clk_i);
    #1;
    check("t5_no_resume", 64'(log_addr.size()), 64'd22);
    check("t5_idle", 64'(wb_state_o), 64'd0);

    // Negative lanes
    mem[0] = '0;
    mem[0][31:0] = 32'h807F11F0;
    run_start(18'h010, 17'd1);
    wait_done(40, cyc);
    check("t6_nbeats", 64'(log_addr.size()), 64'd4);
    if (log_data.size() > 0) begin
`ifdef WB_RELU_EN
      check("t6_lane_clamp", 64'(log_data[0]), 64'h007F1100);
`else
      check("t6_lane_pass", 64'(log_data[0]), 64'h807F11F0);
`endif
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/output_writeback_ctrl.md
OUTPUT_WRITEBACK_CTRL -- requirements
Module: output_writeback_ctrl

Interface
REQ-001 SHALL have parameter DRAM_ADDR_WIDTH, default 18: DRAM word-address width.
REQ-002 SHALL have parameter OUTPUT_ADDR_WIDTH, default 16: output-buffer address width.
REQ-003 SHALL have parameter DATA_IN_DRAM_WIDTH, default 32: DRAM word width.
REQ-004 SHALL have parameter N_COLS_ARRAY, default 16: output lanes per buffer entry.
REQ-005 SHALL have parameter O_WIDTH, default 8: bits per lane, signed two's complement.
REQ-006 SHALL have port clk_i, input, 1 bit: the single clock.
REQ-007 SHALL have port general_rst_i, input, 1 bit: asynchronous, active-high reset.
REQ-008 SHALL have port start_i, input, 1 bit: write-back request.
REQ-009 SHALL have port output_start_addr_dram_i, input, DRAM_ADDR_WIDTH: first DRAM destination word.
REQ-010 SHALL have port output_count_i, input, OUTPUT_ADDR_WIDTH+1: number of buffer entries to write back.
REQ-011 SHALL have port obuf_rd_address_o, output, OUTPUT_ADDR_WIDTH: output-buffer read address.
REQ-012 SHALL have port obuf_rd_data_i, input, O_WIDTH*N_COLS_ARRAY: buffer data, valid one cycle after its address.
REQ-013 SHALL have port dram_wr_en_o, output, 1 bit: beat valid.
REQ-014 SHALL have port dram_wr_ready_i, input, 1 bit: DRAM accepts the beat.
REQ-015 SHALL have port dram_wr_address_o, output, DRAM_ADDR_WIDTH: DRAM write address.
REQ-016 SHALL have port dram_wr_data_o, output, DATA_IN_DRAM_WIDTH: DRAM write data.
REQ-017 SHALL have port done_o, output, 1 bit: write-back complete.
REQ-018 SHALL have port wb_state_o, output, 3 bits: present FSM state.

Function
REQ-019 SHALL implement an FSM with states IDLE=000, FETCH=001, LATCH=010, WRITE=011 and DONE=100, and SHALL drive the present state on wb_state_o.
REQ-020 In IDLE with start_i=1, SHALL latch output_start_addr_dram_i and output_count_i; SHALL go to DONE if the count is 0, otherwise to FETCH.
REQ-021 In FETCH (1 cycle), SHALL drive obuf_rd_address_o with the entry index, starting at 0.
REQ-022 In LATCH (1 cycle), SHALL capture obuf_rd_data_i into an entry register.
REQ-023 SHALL serialise each entry into BEATS = ceil(O_WIDTH*N_COLS_ARRAY / DATA_IN_DRAM_WIDTH) beats, least-significant bits first, zero-padding the upper bits of the last beat.
REQ-024 In WRITE, SHALL hold dram_wr_en_o=1.
REQ-025 A beat SHALL transfer only in a cycle where dram_wr_en_o=1 and dram_wr_ready_i=1.
REQ-026 dram_wr_address_o and dram_wr_data_o SHALL remain stable while dram_wr_en_o=1 and dram_wr_ready_i=0.
REQ-027 dram_wr_address_o SHALL equal the latched start address plus the count of beats transferred, wrapping modulo 2^DRAM_ADDR_WIDTH.
REQ-028 On transfer of the last beat of an entry, SHALL go to FETCH with the entry index +1, or to DONE if that entry was entry output_count_i-1.
REQ-029 dram_wr_en_o SHALL be 0 in every state other than WRITE.
REQ-030 Minimum cost per entry SHALL be 2+BEATS cycles.
REQ-031 done_o SHALL be 1 only in DONE.
REQ-032 SHALL leave DONE for IDLE when start_i=0; a start_i held high SHALL NOT retrigger.
REQ-033 start_i SHALL be ignored outside IDLE.
REQ-034 A count of 2^OUTPUT_ADDR_WIDTH SHALL write the entire buffer, with the entry index wrapping only after completion.

Reset
REQ-035 general_rst_i=1 SHALL immediately force IDLE and clear obuf_rd_address_o, dram_wr_address_o, dram_wr_data_o, dram_wr_en_o, done_o, the entry register and all counters to 0, without waiting for a clock edge.
REQ-036 Reset asserted mid-transfer SHALL abort the transfer: no further beats, and no resumption after reset release.

Configuration
REQ-037 With macro WB_RELU_EN defined, SHALL replace each negative O_WIDTH lane with 0 at capture in LATCH; without it, lanes SHALL pass unmodified.
REQ-038 The macro SHALL NOT change the ports or the timing.

Verification
REQ-039 Count 2, start address 0x100, ready tied to 1, entry0 lanes = 0x00..0x0F, entry1 = 0x10..0x1F -> 8 beats to 0x100-0x107; first beat 0x03020100; done_o asserted 12 cycles after start is sampled.
REQ-040 Count 1, ready low for 3 cycles during beat 2 -> beat 2 address and data held stable throughout, no duplicate or missing beat.
REQ-041 Count 0 -> DONE in 1 cycle, dram_wr_en_o never asserted.
REQ-042 Start address 0x3FFFE, count 1 -> beat addresses 0x3FFFE, 0x3FFFF, 0x00000, 0x00001.
REQ-043 Reset asserted during beat 3 of entry 5 -> dram_wr_en_o=0 at once, state 000, idle after release.
REQ-044 With WB_RELU_EN defined, lane value 0xF0 -> written as 0x00; without it, written as 0xF0.
